// File: rtl/syscall_print_ctrl.sv
// SYSCALL service sequencer: stalls the pipeline, borrows the data-memory read port and streams
// print-string / print-int / exit results. Define PRINT_INT_EN to enable the print-int (v0=1) service.
module syscall_print_ctrl #(
    parameter int MAX_LEN = 256,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              syscall_req,
    input  logic [31:0]       v0,
    input  logic [31:0]       a0,
    input  logic              mem_busy,
    output logic              stall_o,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              out_valid,
    output logic              out_is_int,
    output logic [31:0]       out_data,
    input  logic              out_ready,
    output logic              done_o,
    output logic              trunc_o,
    output logic              halt_o
);

    localparam int CNT_W = $clog2(MAX_LEN + 1);

    localparam logic [31:0] CODE_PRINT_INT = 32'd1;
    localparam logic [31:0] CODE_PRINT_STR = 32'd4;
    localparam logic [31:0] CODE_EXIT      = 32'd10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_FETCH,
        S_EMIT,
        S_DONE,
        S_HALT
`ifdef PRINT_INT_EN
        , S_INT
`endif
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q,   ptr_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [31:0]       word_q,  word_d;   // fetched word, or the print-int value
    logic              trunc_q, trunc_d;
    logic              halt_q,  halt_d;
    logic [7:0]        cur_byte;

    // Little-endian byte lane addressed by the low pointer bits.
    always_comb begin
        case (ptr_q[1:0])
            2'd0:    cur_byte = word_q[7:0];
            2'd1:    cur_byte = word_q[15:8];
            2'd2:    cur_byte = word_q[23:16];
            default: cur_byte = word_q[31:24];
        endcase
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        trunc_d    = trunc_q;
        halt_d     = halt_q;
        stall_o    = 1'b0;
        mem_req    = 1'b0;
        mem_addr   = '0;
        out_valid  = 1'b0;
        out_is_int = 1'b0;
        out_data   = '0;
        done_o     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Stall the same cycle the request shows up so the syscall never slips past D.
                stall_o = syscall_req;
                if (syscall_req) begin
                    trunc_d = 1'b0;
                    if (v0 == CODE_PRINT_STR) begin
                        state_d = S_DRAIN;
                        ptr_d   = a0[ADDR_W-1:0];
                        cnt_d   = '0;
`ifdef PRINT_INT_EN
                    end else if (v0 == CODE_PRINT_INT) begin
                        state_d = S_INT;
                        word_d  = a0;
`endif
                    end else if (v0 == CODE_EXIT) begin
                        state_d = S_HALT;
                        halt_d  = 1'b1;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DRAIN: begin
                stall_o = 1'b1;
                if (!mem_busy) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                stall_o  = 1'b1;
                mem_addr = {ptr_q[ADDR_W-1:2], 2'b00};
                // The MEM stage owns the port whenever it asks; back off and retry.
                if (mem_busy) begin
                    state_d = S_DRAIN;
                end else begin
                    mem_req = 1'b1;
                    word_d  = mem_rdata;
                    state_d = S_EMIT;
                end
            end

            S_EMIT: begin
                stall_o = 1'b1;
                if (cur_byte == 8'h00) begin
                    state_d = S_DONE;
                end else begin
                    out_valid = 1'b1;
                    out_data  = {24'h0, cur_byte};
                    if (out_ready) begin
                        ptr_d = ptr_q + ADDR_W'(1);
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(MAX_LEN - 1)) begin
                            trunc_d = 1'b1;
                            state_d = S_DONE;
                        end else if (ptr_q[1:0] == 2'b11) begin
                            state_d = S_DRAIN;
                        end
                    end
                end
            end

`ifdef PRINT_INT_EN
            S_INT: begin
                stall_o    = 1'b1;
                out_valid  = 1'b1;
                out_is_int = 1'b1;
                out_data   = word_q;
                if (out_ready) begin
                    state_d = S_DONE;
                end
            end
`endif

            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end

            S_HALT: begin
                stall_o = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            trunc_q <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            trunc_q <= trunc_d;
            halt_q  <= halt_d;
        end
    end

    assign trunc_o = trunc_q;
    assign halt_o  = halt_q;

endmodule

// File: tb/tb_syscall_print_ctrl.sv
// Self-checking bench for syscall_print_ctrl: directed scenarios plus randomized syscalls
// compared against a string-scanning reference model over a byte-array memory.
module tb_syscall_print_ctrl;

    localparam int MAX_LEN = 6;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        syscall_req = 1'b0;
    logic [31:0] v0 = '0;
    logic [31:0] a0 = '0;
    logic        mem_busy = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] mem_rdata;
    logic        stall_o, mem_req, out_valid, out_is_int, done_o, trunc_o, halt_o;
    logic [31:0] mem_addr, out_data;

    syscall_print_ctrl #(.MAX_LEN(MAX_LEN), .ADDR_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .syscall_req(syscall_req), .v0(v0), .a0(a0),
        .mem_busy(mem_busy), .stall_o(stall_o), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .out_valid(out_valid), .out_is_int(out_is_int),
        .out_data(out_data), .out_ready(out_ready), .done_o(done_o), .trunc_o(trunc_o),
        .halt_o(halt_o)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:1023];
    always_comb mem_rdata = {mem[{mem_addr[9:2], 2'd3}], mem[{mem_addr[9:2], 2'd2}],
                             mem[{mem_addr[9:2], 2'd1}], mem[{mem_addr[9:2], 2'd0}]};

    int          checks = 0;
    int          errors = 0;
    logic [32:0] got_q[$];
    logic [32:0] exp_q[$];
    logic        exp_trunc;
    int          held_cnt;
    logic        fetched_104;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic put_str(input int addr, input string s);
        for (int i = 0; i < s.len(); i++) mem[addr + i] = s[i];
        mem[addr + s.len()] = 8'h00;
    endtask

    // Reference: chars from addr up to NUL, at most MAX_LEN of them.
    task automatic model_string(input logic [31:0] addr);
        logic [9:0] p;
        int n;
        exp_q.delete();
        p = addr[9:0];
        n = 0;
        while (mem[p] != 8'h00 && n < MAX_LEN) begin
            exp_q.push_back({1'b0, 24'h0, mem[p]});
            p++;
            n++;
        end
        exp_trunc = (n == MAX_LEN);
    endtask

    task automatic model_int(input logic [31:0] val);
        exp_q.delete();
`ifdef PRINT_INT_EN
        exp_q.push_back({1'b1, val});
`else
        if (val == 32'h0) exp_q.delete();
`endif
        exp_trunc = 1'b0;
    endtask

    task automatic compare_items(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check({tag, "_data"}, got_q[i][31:0], exp_q[i][31:0]);
            check({tag, "_kind"}, {31'h0, got_q[i][32]}, {31'h0, exp_q[i][32]});
        end
        check({tag, "_trunc"}, {31'h0, trunc_o}, {31'h0, exp_trunc});
    endtask

    // rdy_mode: 0 always ready, 1 random, 2 stall 3 cycles on 'C'.
    // busy_mode: 0 idle, 1 random, 2 busy for the first 4 cycles after accept.
    task automatic run_service(input logic [31:0] code, input logic [31:0] arg,
                               input int rdy_mode, input int busy_mode, output int cycles);
        logic        done_seen, pv, pr;
        logic [31:0] pd;
        done_seen = 1'b0; pv = 1'b0; pr = 1'b0; pd = '0;
        held_cnt = 0;
        fetched_104 = 1'b0;
        got_q.delete();
        v0 = code; a0 = arg; syscall_req = 1'b1;
        #1;
        check("stall_on_req", {31'h0, stall_o}, 32'h1);
        cycles = 0;
        while (!done_seen && cycles < 2000) begin
            @(posedge clk); #1;
            cycles++;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (out_valid && out_data == 32'h43 && held_cnt < 3) begin
                        out_ready = 1'b0;
                        held_cnt++;
                    end else out_ready = 1'b1;
                end
            endcase
            case (busy_mode)
                0: mem_busy = 1'b0;
                1: mem_busy = ($urandom_range(0, 2) == 0);
                default: mem_busy = (cycles <= 4);
            endcase
            @(negedge clk);
            if (mem_busy) check("req_vs_busy", {31'h0, mem_req}, 32'h0);
            if (pv && !pr) begin
                check("valid_hold", {31'h0, out_valid}, 32'h1);
                check("data_hold", out_data, pd);
            end
            pv = out_valid; pr = out_ready; pd = out_data;
            if (mem_req && mem_addr == 32'h104) fetched_104 = 1'b1;
            if (out_valid && out_ready) got_q.push_back({out_is_int, out_data});
            if (done_o) begin
                done_seen = 1'b1;
                check("stall_in_done", {31'h0, stall_o}, 32'h0);
                syscall_req = 1'b0;
            end else begin
                check("stall_busy", {31'h0, stall_o}, 32'h1);
            end
        end
        if (!done_seen) check("done_timeout", 32'h0, 32'h1);
        @(posedge clk); #1;
        out_ready = 1'b0; mem_busy = 1'b0;
        @(negedge clk);
        check("done_single", {31'h0, done_o}, 32'h0);
        check("idle_stall", {31'h0, stall_o}, 32'h0);
        check("idle_valid", {31'h0, out_valid}, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        int          kind, len;
        logic [31:0] addr, val, code;

        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;

        // Reset state.
        #1;
        check("rst_stall", {31'h0, stall_o}, 32'h0);
        check("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_valid", {31'h0, out_valid}, 32'h0);
        check("rst_data", out_data, 32'h0);
        check("rst_done", {31'h0, done_o}, 32'h0);
        check("rst_trunc", {31'h0, trunc_o}, 32'h0);
        check("rst_halt", {31'h0, halt_o}, 32'h0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;

        // "Hi" aligned, no contention, always ready: bounded latency.
        put_str(32'h100, "Hi");
        model_string(32'h100);
        run_service(32'd4, 32'h100, 0, 0, cyc);
        compare_items("hi");
        check("hi_latency", {31'h0, (cyc <= 6)}, 32'h1);

        // Unaligned start: only 0x43 emitted, next word never fetched.
        mem[32'h100] = 8'h59; mem[32'h101] = 8'h58; mem[32'h102] = 8'h43; mem[32'h103] = 8'h00;
        for (int i = 0; i < 4; i++) mem[32'h104 + i] = 8'h00;
        model_string(32'h102);
        run_service(32'd4, 32'h102, 0, 0, cyc);
        compare_items("unaligned");
        check("no_fetch_104", {31'h0, fetched_104}, 32'h0);

        // Back-pressure on 'C' for 3 cycles.
        put_str(32'h200, "ABCDE");
        model_string(32'h200);
        run_service(32'd4, 32'h200, 2, 0, cyc);
        compare_items("backpress");
        check("backpress_held", held_cnt, 32'd3);

        // MEM stage holds the port for 4 cycles after accept.
        run_service(32'd4, 32'h200, 0, 2, cyc);
        compare_items("contention");

        // Truncation at MAX_LEN, then cleared by the next accepted syscall.
        put_str(32'h240, "ABCDEFGHI");
        model_string(32'h240);
        run_service(32'd4, 32'h240, 0, 0, cyc);
        compare_items("trunc");
        exp_q.delete(); exp_trunc = 1'b0;
        run_service(32'd7, 32'h0, 0, 0, cyc);
        compare_items("unsupported");

        // Print-int (or unsupported when the service is compiled out).
        model_int(32'hFFFF_FFF9);
        run_service(32'd1, 32'hFFFF_FFF9, 0, 0, cyc);
        compare_items("print_int");

        // Randomized mix with random back-pressure and memory contention.
        for (int t = 0; t < 24; t++) begin
            kind = $urandom_range(0, 4);
            if (kind <= 2) begin
                addr = 32'h300 + $urandom_range(0, 32'hF0);
                len  = $urandom_range(0, 9);
                for (int i = 0; i < len; i++) mem[addr + i] = 8'($urandom_range(1, 255));
                mem[addr + len] = 8'h00;
                model_string(addr);
                code = 32'd4;
                val  = addr;
            end else if (kind == 3) begin
                val  = $urandom;
                model_int(val);
                code = 32'd1;
            end else begin
                val  = $urandom;
                code = 32'd11 + $urandom_range(0, 50);
                exp_q.delete(); exp_trunc = 1'b0;
            end
            run_service(code, val, 1, 1, cyc);
            compare_items("random");
        end

        // Reset in the middle of a string service.
        syscall_req = 1'b1; v0 = 32'd4; a0 = 32'h200; out_ready = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_stalled", {31'h0, stall_o}, 32'h1);
        reset_n = 1'b0; syscall_req = 1'b0;
        #1;
        check("mid_rst_stall", {31'h0, stall_o}, 32'h0);
        check("mid_rst_valid", {31'h0, out_valid}, 32'h0);
        check("mid_rst_req", {31'h0, mem_req}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        put_str(32'h100, "Hi");
        model_string(32'h100);
        run_service(32'd4, 32'h100, 0, 0, cyc);
        compare_items("after_rst");

        // Exit: halt is sticky and keeps the pipeline stalled until reset.
        syscall_req = 1'b1; v0 = 32'd10; a0 = 32'h0;
        @(negedge clk);
        syscall_req = 1'b0;
        check("halt_set", {31'h0, halt_o}, 32'h1);
        check("halt_stall", {31'h0, stall_o}, 32'h1);
        syscall_req = 1'b1; v0 = 32'd4; a0 = 32'h100;
        repeat (5) @(negedge clk);
        check("halt_sticky", {31'h0, halt_o}, 32'h1);
        check("halt_no_done", {31'h0, done_o}, 32'h0);
        check("halt_no_req", {31'h0, mem_req}, 32'h0);
        syscall_req = 1'b0;
        reset_n = 1'b0;
        #1;
        check("halt_cleared", {31'h0, halt_o}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
